// File: rtl/mdr_arbiter.sv
// Round-robin arbiter sharing one serial-load multiply/divide/root datapath
// between two requesters, with operand sequencing and a completion timeout.
module mdr_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [N-1:0] x0,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y0,
    input  logic [N-1:0] y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [N-1:0] res,
    output logic [N-1:0] rem,
    output logic         err,
    output logic         mdr_load,
    output logic [N-1:0] mdr_data,
    output logic [1:0]   mdr_op,
    output logic         mdr_start,
    input  logic [N-1:0] mdr_result,
    input  logic [N-1:0] mdr_remainder,
    input  logic         mdr_done
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_X, GAP_X, LOAD_Y, GAP_Y, START, WAIT, RESP
    } state_e;

    state_e       state_q;
    logic         last_q;
    logic         port_q;
    logic [N-1:0] y_q;
    logic [CW-1:0] cnt_q;
    logic         gnt0_q, gnt1_q, done0_q, done1_q, err_q;
    logic         mdr_load_q, mdr_start_q;
    logic [N-1:0] res_q, rem_q, mdr_data_q;
    logic [1:0]   mdr_op_q;

    logic         win_d;
    logic [1:0]   op_d;
    logic [N-1:0] x_d, y_d;

    always_comb begin
        win_d = (req0 && req1) ? ~last_q : req1;
        op_d  = win_d ? op1 : op0;
        x_d   = win_d ? x1 : x0;
        y_d   = win_d ? y1 : y0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            y_q         <= '0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err_q       <= 1'b0;
            res_q       <= '0;
            rem_q       <= '0;
            mdr_load_q  <= 1'b0;
            mdr_start_q <= 1'b0;
            mdr_data_q  <= '0;
            mdr_op_q    <= '0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            mdr_load_q  <= 1'b0;
            mdr_start_q <= 1'b0;
            case (state_q)
                IDLE: if (req0 || req1) begin
                    last_q <= win_d;
                    port_q <= win_d;
                    y_q    <= y_d;
                    gnt0_q <= ~win_d;
                    gnt1_q <= win_d;
                    // Reserved op never touches the datapath; done follows a cycle later.
                    if (op_d == 2'd3) begin
                        res_q   <= '0;
                        rem_q   <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        mdr_load_q <= 1'b1;
                        mdr_data_q <= x_d;
                        mdr_op_q   <= op_d;
                        state_q    <= LOAD_X;
                    end
                end
                LOAD_X: state_q <= GAP_X;
                GAP_X: begin
                    mdr_load_q <= 1'b1;
                    mdr_data_q <= y_q;
                    state_q    <= LOAD_Y;
                end
                LOAD_Y: state_q <= GAP_Y;
                GAP_Y: begin
                    mdr_start_q <= 1'b1;
                    state_q     <= START;
                end
                START: state_q <= WAIT;
                WAIT: begin
                    if (mdr_done) begin
                        res_q   <= mdr_result;
                        rem_q   <= mdr_remainder;
                        err_q   <= 1'b0;
                        done0_q <= ~port_q;
                        done1_q <= port_q;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        res_q   <= '0;
                        rem_q   <= '0;
                        err_q   <= 1'b1;
                        done0_q <= ~port_q;
                        done1_q <= port_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (done0_q || done1_q) begin
                        done0_q <= 1'b0;
                        done1_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        done0_q <= ~port_q;
                        done1_q <= port_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign res       = res_q;
    assign rem       = rem_q;
    assign err       = err_q;
    assign mdr_load  = mdr_load_q;
    assign mdr_data  = mdr_data_q;
    assign mdr_op    = mdr_op_q;
    assign mdr_start = mdr_start_q;
endmodule

// File: tb/tb_mdr_arbiter.sv
// Transaction-level bench for mdr_arbiter: predicts winner, strobe cycles and
// response timing for each round and checks the DUT cycle by cycle.
module tb_mdr_arbiter;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [3:0] x0, x1, y0, y1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [3:0] res, rem, mdr_data;
    logic       mdr_load, mdr_start;
    logic [1:0] mdr_op;
    logic [3:0] mdr_result, mdr_remainder;
    logic       mdr_done;
    logic [20:0] outs_w;

    int n_chk  = 0;
    int n_pass = 0;

    bit         pend [2];
    logic [1:0] p_op [2];
    logic [3:0] p_x  [2];
    logic [3:0] p_y  [2];
    int         last_m;

    mdr_arbiter #(.N(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .rem(rem), .err(err),
        .mdr_load(mdr_load), .mdr_data(mdr_data), .mdr_op(mdr_op), .mdr_start(mdr_start),
        .mdr_result(mdr_result), .mdr_remainder(mdr_remainder), .mdr_done(mdr_done)
    );

    always #5 clk = ~clk;

    assign outs_w = {gnt0, gnt1, done0, done1, res, rem, err,
                     mdr_load, mdr_data, mdr_op, mdr_start};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic drive_ports();
        req0 = pend[0]; op0 = p_op[0]; x0 = p_x[0]; y0 = p_y[0];
        req1 = pend[1]; op1 = p_op[1]; x1 = p_x[1]; y1 = p_y[1];
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        pend[p] = 1'b1;
        p_op[p] = op;
        p_x[p]  = x;
        p_y[p]  = y;
        drive_ports();
    endtask

    // Called in the IDLE cycle (cycle 0); returns in the next IDLE cycle.
    // lat: datapath raises mdr_done lat cycles after the start cycle (0 = never).
    task automatic run_round(input int lat, input logic [3:0] r, input logic [3:0] m);
        int         win, dcyc;
        bit         rsv, dp_fires;
        logic [3:0] er, em;
        logic       ee;
        if (pend[0] && pend[1]) win = (last_m == 1) ? 0 : 1;
        else                    win = pend[1] ? 1 : 0;
        last_m   = win;
        rsv      = (p_op[win] == 2'd3);
        dp_fires = (lat >= 1);
        if (rsv) begin
            dcyc = 2; er = 4'h0; em = 4'h0; ee = 1'b1;
        end else if (lat >= 1 && lat <= TO + 1) begin
            dcyc = 6 + lat; er = r; em = m; ee = 1'b0;
        end else begin
            dcyc = 7 + TO; er = 4'h0; em = 4'h0; ee = 1'b1;
        end
        mdr_result    = r;
        mdr_remainder = m;
        mdr_done      = 1'b0;
        for (int c = 1; c <= dcyc; c++) begin
            @(posedge clk); #1;
            chk("gnt0",  gnt0,  (win == 0) && (c == 1));
            chk("gnt1",  gnt1,  (win == 1) && (c == 1));
            chk("done0", done0, (win == 0) && (c == dcyc));
            chk("done1", done1, (win == 1) && (c == dcyc));
            chk("load",  mdr_load,  !rsv && (c == 1 || c == 3));
            chk("start", mdr_start, !rsv && (c == 5));
            if (!rsv && c == 1) chk("data_x", mdr_data, p_x[win]);
            if (!rsv && c == 3) chk("data_y", mdr_data, p_y[win]);
            if (!rsv && c <= 6) chk("op", mdr_op, p_op[win]);
            if (c == dcyc) begin
                chk("res", res, er);
                chk("rem", rem, em);
                chk("err", err, ee);
            end
            if (c == 1) begin
                pend[win] = 1'b0;
                drive_ports();
            end
            // Spurious completions before WAIT must be ignored.
            if (c <= 4) mdr_done = ($urandom_range(0, 3) == 0);
            else        mdr_done = !rsv && dp_fires && (c == 5 + lat);
        end
        @(posedge clk); #1;
        mdr_done = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            p_op[p] = 2'd0; p_x[p] = 4'h0; p_y[p] = 4'h0;
        end
        drive_ports();
        mdr_done = 1'b0; mdr_result = 4'h0; mdr_remainder = 4'h0;
        last_m = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs_w, 21'h0);
        rst = 1'b1;

        // Simultaneous requests straight after reset, then alternating rounds.
        set_req(0, 2'd0, 4'h1, 4'h2);
        set_req(1, 2'd1, 4'h3, 4'h4);
        run_round(1, 4'ha, 4'hb);
        run_round(2, 4'hc, 4'hd);
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p]) set_req(p, 2'(k % 3), 4'(k + 5), 4'(k + 9));
            run_round(k + 1, 4'(k), 4'(15 - k));
        end
        while (pend[0] || pend[1]) run_round(3, 4'h6, 4'h7);

        set_req(0, 2'd2, 4'b0111, 4'b0011);
        run_round(4, 4'b0101, 4'b0001);

        set_req(1, 2'd3, 4'hf, 4'he);
        run_round(2, 4'h9, 4'h9);

        set_req(0, 2'd1, 4'h8, 4'h2);
        run_round(0, 4'h3, 4'h3);
        set_req(0, 2'd0, 4'h5, 4'h6);
        run_round(2, 4'h7, 4'h8);

        set_req(1, 2'd2, 4'h4, 4'h1);
        run_round(TO + 1, 4'hd, 4'h2);

        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
            if (!pend[0] && !pend[1])
                set_req(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
            run_round(int'($urandom_range(0, TO + 2)), 4'($urandom), 4'($urandom));
        end
        while (pend[0] || pend[1]) run_round(1, 4'h1, 4'h2);

        // Reset asserted mid-cycle while the datapath is busy.
        set_req(0, 2'd1, 4'h9, 4'h2);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                pend[0] = 1'b0;
                drive_ports();
            end
        end
        #3 rst = 1'b0;
        #1;
        chk("rst_async", outs_w, 21'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst_hold", outs_w, 21'h0);
        end
        rst = 1'b1;
        last_m = 1;
        set_req(0, 2'd0, 4'h3, 4'h4);
        run_round(2, 4'hc, 4'hd);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
